// File: rtl/product_accumulator.sv
// Burst accumulator for multiplier products: sums up to N terms per burst and
// presents the registered sum, term count and sticky overflow with a valid/ready handshake.
module product_accumulator #(
  parameter int unsigned N     = 4,
  parameter int unsigned ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_product,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [3:0]       out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned PROD_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SUM_W  = ACC_W + 1;

  typedef enum logic {
    S_ACC  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;

  logic               in_acc_c;
  logic               out_acc_c;
  logic               burst_end_c;
  logic [SUM_W-1:0]   sum_c;
  logic [SUM_W-1:0]   prod_ext_c;

  // Handshake qualifiers use only the registered ready/valid, so in_* never reaches out_* combinationally.
  assign in_acc_c    = in_valid & ready_q;
  assign out_acc_c   = valid_q & out_ready;
  assign prod_ext_c  = SUM_W'(in_product[PROD_W-1:0]);
  assign sum_c       = {1'b0, acc_q} + prod_ext_c;
  assign burst_end_c = in_last | (cnt_q == CNT_W'(N - 1));

  // State register; reset clears everything, discarding any partial or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and datapath; ready/valid are registered decodes of the next state.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_ACC: begin
        if (in_acc_c) begin
          acc_d = sum_c[ACC_W-1:0];
          cnt_d = cnt_q + CNT_W'(1);
          ovf_d = ovf_q | sum_c[ACC_W];
          if (burst_end_c) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_acc_c) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_ACC;
        end
      end
      default: begin
        state_d = S_ACC;
      end
    endcase

    ready_d = (state_d == S_ACC);
    valid_d = (state_d == S_HOLD);
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter N, default 4: maximum number of products per burst (legal range 1..15).
REQ-002 Parameter ACC_W, default 12: accumulator and result width (legal range 8..16).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_product  input  8  unsigned product from the 4x4 multiplier stage.
REQ-006 in_valid  input  1  in_product is valid this cycle.
REQ-007 in_last  input  1  qualifies in_product as the final term of the burst; sampled only on accept.
REQ-008 in_ready  output  1  block can accept a term this cycle.
REQ-009 out_sum  output  ACC_W  accumulated burst sum.
REQ-010 out_count  output  4  number of terms in the burst.
REQ-011 out_ovf  output  1  sticky flag: the burst sum exceeded 2^ACC_W-1.
REQ-012 out_valid  output  1  out_sum, out_count and out_ovf are valid.
REQ-013 out_ready  input  1  consumer accepts the result.

Function
REQ-014 The block SHALL use a two-state FSM: ACC and HOLD.
REQ-015 Input accept SHALL occur when in_valid=1 and in_ready=1 on the same edge; out accept SHALL occur when out_valid=1 and out_ready=1 on the same edge.
REQ-016 ACC state:
- in_ready=1, out_valid=0.
- On input accept: acc <= acc + zero-extended in_product, truncated to ACC_W; cnt <= cnt+1.
- If the carry out of bit ACC_W-1 is 1, ovf <= 1.
REQ-017 ACC state, burst end: if an input accept has in_last=1, or cnt = N-1 before the add, the FSM SHALL go to HOLD on that same edge, with the final sum, count and ovf registered.
REQ-018 Latency: out_valid SHALL assert on the cycle immediately after the accept of the final term.
REQ-019 HOLD state: in_ready=0, out_valid=1. out_sum, out_count and out_ovf SHALL stay stable until out accept.
REQ-020 On out accept, on that edge: acc, cnt and ovf SHALL clear to 0, and the FSM SHALL return to ACC. in_ready SHALL be 1 on the following cycle (no input accept occurs in the out-accept cycle).
REQ-021 ACC with no input accept SHALL hold all state; in_valid=0 bubbles are allowed between terms.
REQ-022 The accumulator SHALL wrap modulo 2^ACC_W. ovf SHALL be sticky for the burst and SHALL clear only on out accept or reset.
REQ-023 in_last and the cnt=N-1 cap arriving together SHALL end the burst exactly once, with out_count=N.
REQ-024 in_product, in_last and out_ready SHALL be ignored in any cycle where they do not form an accept.
REQ-025 The outputs SHALL be registered, with no combinational path from in_* to out_*. in_ready SHALL depend on FSM state only.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force:
- FSM=ACC, acc=0, cnt=0, ovf=0.
- out_sum=0, out_count=0, out_ovf=0, out_valid=0, in_ready=0.
REQ-027 in_ready SHALL rise on the first rising clk edge after rst_n deasserts.
REQ-028 Reset asserted mid-burst or in HOLD SHALL discard the partial or pending result without emitting it.

Verification
REQ-029 N=4, ACC_W=12, four back-to-back terms of 225, out_ready=1 -> out_sum=900 (0x384), out_count=4, out_ovf=0; out_valid high exactly one cycle, the cycle after the 4th accept.
REQ-030 Terms 10 then 20 with in_last=1 on the 20 -> out_sum=30, out_count=2; the next burst starts from acc=0.
REQ-031 ACC_W=9, four terms of 225 -> out_sum=388, out_ovf=1. The following burst with term 5 and in_last=1 -> out_sum=5, out_ovf=0.
REQ-032 Result pending with out_ready held low 3 cycles -> out_sum, out_count and out_ovf are stable, in_ready=0, and offered in_valid terms are not consumed; on the 4th cycle out_ready=1 -> out accept, and in_ready=1 on the next cycle.
REQ-033 rst_n pulsed low after 2 of 4 terms (values 7 and 9) -> outputs reset immediately with no out_valid. A new 1-term burst of 3 with in_last=1 -> out_sum=3, out_count=1.
REQ-034 Terms 1,2,3,4 with in_valid=0 gaps of random length and in_last=1 on the 4th term -> a single result with out_sum=10 and out_count=4.
